vcr_display_scheduler: RTL and testbench
========================================

Name: vcr_display_scheduler

Overview:
- Controller between vcr_decoder (4-bit code plus "outputting" strobe) and the DisplayDecoder / seven-segment anodes.
- Turns each new IR keypress into a one-shot event and builds a NUM_DIGITS-deep digit entry buffer.
- Handles CLEAR, BACKSPACE and idle-timeout blanking.
- Time-multiplexes the buffer onto one DisplayDecoder, so several digits share a single segment bus.

Parameters:
- NUM_DIGITS, 4, buffer depth and number of anodes scanned.
- SCAN_DIV, 25, clk cycles per digit slot (10 kHz / 25 = 400 Hz per slot).
- TIMEOUT_TICKS, 50000, idle clk cycles before auto-blank (5 s at 10 kHz).

Ports:
- clk  in  1  system clock (10 kHz domain, same as vcr_decoder).
- reset  in  1  asynchronous, active-high reset.
- code_valid  in  1  vcr_decoder "outputting" level; high while a code is presented.
- code  in  4  decoded key: 0-9 digit, 4'hA CLEAR, 4'hB BACKSPACE, others ignored.
- digit_data  out  4  nibble to DisplayDecoder for the current slot.
- digit_sel  out  NUM_DIGITS  active-low one-hot anode select.
- blank  out  1  1 = segments for the current slot are suppressed by the parent.
- entry_count  out  $clog2(NUM_DIGITS+1)  number of digits entered.
- overflow  out  1  one-cycle pulse when a digit arrives while FULL.
- timeout  out  1  one-cycle pulse when idle auto-blank fires.

Behaviour:
- Reset (async, immediate):
  - state=BLANK, buffer=0, entry_count=0, scan index=0, scan divider=0, idle counter=0.
  - digit_sel=~1 (slot 0 active), digit_data=0, blank=1, overflow=0, timeout=0.
  - Reset asserted mid-entry discards all digits.
- Event detect:
  - prev_valid register; event = code_valid & ~prev_valid, sampled at the clk edge.
  - A held code_valid produces exactly one event.
  - The code value is taken on the event cycle.
  - Effects of an event are visible on all outputs at the next edge (latency 1).
- Buffer:
  - buf[0] is the least significant digit and is shown on slot 0.
  - Digit shift-in: buf[i] <= buf[i-1], buf[0] <= code.
  - Backspace: buf[i] <= buf[i+1], top <= 0.
- States:
  - BLANK: a digit event shifts the digit in, entry_count=1, go to ENTRY. CLEAR and BACKSPACE are no-ops. blank=1 on all slots.
  - ENTRY: a digit event shifts in and increments entry_count; on reaching NUM_DIGITS go to FULL.
    - BACKSPACE decrements entry_count; on reaching 0 clear the buffer and go to BLANK.
    - CLEAR zeroes the buffer and count and goes to BLANK.
  - FULL: a digit event is dropped (buffer unchanged) and overflow pulses. BACKSPACE goes to ENTRY with count NUM_DIGITS-1. CLEAR goes to BLANK.
  - Ignored codes (4'hC-4'hF) change nothing and do not restart the idle counter.
- Idle timeout:
  - The counter clears on every accepted event (digit, CLEAR, BACKSPACE, or dropped digit).
  - Otherwise it increments while in ENTRY or FULL and is held at 0 in BLANK.
  - At TIMEOUT_TICKS-1: go to BLANK, clear the buffer, pulse timeout.
  - If an event and the timeout coincide, the event wins, the counter clears and no timeout pulses.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the index advances 0..NUM_DIGITS-1 and wraps to 0.
  - digit_sel, digit_data and blank are registered and update on the wrap edge only.
  - digit_data = buf[next index].
  - The scan runs continuously in all states.
- entry_count never exceeds NUM_DIGITS and never underflows.

Optional Feature:
- LEADING_ZERO_BLANK_EN.
- Defined: in ENTRY/FULL, slot i is blanked (blank=1) when i >= entry_count, so only the entered digits light.
- Undefined: in ENTRY/FULL all NUM_DIGITS slots are lit, and unentered slots show 0 (for example "0012").
- BLANK state blanks all slots in both builds.

Decomposition:
- Package vcr_pkg:
  - typedef enum logic [1:0] {BLANK, ENTRY, FULL} sched_state_t.
  - localparams CODE_CLEAR=4'hA, CODE_BKSP=4'hB, CODE_DIGIT_MAX=4'h9.
- One sub-module vcr_scan_counter: SCAN_DIV divider plus slot index, outputting the index and a wrap strobe.
- The FSM, buffer and idle counter stay in the top.

Test Plan:
- Reset, then code_valid held high 10 cycles with code=3 -> exactly one event; entry_count=1, buf[0]=3, state ENTRY.
- Keys 1,2,3,4 -> FULL with buffer 1234; key 5 -> overflow pulses once and the buffer stays 1234.
- Keys 7,8, then BACKSPACE -> entry_count=1, buf[0]=7; BACKSPACE again -> BLANK with blank=1 on all slots.
- Key 9, then no events for TIMEOUT_TICKS-1 cycles -> timeout pulse, BLANK, buffer 0; a key arriving on that exact cycle -> no timeout, count=2.
- Run 4*SCAN_DIV cycles with buffer 0012 -> digit_sel walks 1110, 1101, 1011, 0111 and digit_data follows 2, 1, 0, 0. With LEADING_ZERO_BLANK_EN, blank=1 on slots 2-3.
- Assert reset mid-entry (count=3) -> all outputs are at reset values before the next clk edge.

Source files
------------

// File: rtl/vcr_pkg.sv
// Shared types and key codes for the VCR display scheduler.
package vcr_pkg;

  typedef enum logic [1:0] {BLANK, ENTRY, FULL} sched_state_t;

  localparam logic [3:0] CODE_CLEAR     = 4'hA;
  localparam logic [3:0] CODE_BKSP      = 4'hB;
  localparam logic [3:0] CODE_DIGIT_MAX = 4'h9;

  // Bit width needed to hold 0..count-1, never less than one bit.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/vcr_display_scheduler_if.sv
// Key input and display output bundle between the IR decoder side and the scheduler.
interface vcr_display_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int COUNT_W = $clog2(NUM_DIGITS + 1);

  logic                  code_valid;
  logic [3:0]            code;
  logic [3:0]            digit_data;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic                  blank;
  logic [COUNT_W-1:0]    entry_count;
  logic                  overflow;
  logic                  timeout;

  modport master (
    output code_valid, code,
    input  digit_data, digit_sel, blank, entry_count, overflow, timeout
  );

  modport slave (
    input  code_valid, code,
    output digit_data, digit_sel, blank, entry_count, overflow, timeout
  );
endinterface

// File: rtl/vcr_scan_counter.sv
// Slot timer for display multiplexing: SCAN_DIV clocks per slot, NUM_DIGITS slots.
module vcr_scan_counter
  import vcr_pkg::*;
#(
  parameter int SCAN_DIV   = 25,
  parameter int NUM_DIGITS = 4,
  parameter int INDEX_W    = width_of(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [INDEX_W-1:0] index,
  output logic               wrap
);
  localparam int DIV_W = width_of(SCAN_DIV);

  logic [DIV_W-1:0]   div_reg;
  logic [INDEX_W-1:0] index_reg;

  assign wrap = (div_reg == DIV_W'(SCAN_DIV - 1));

  // index is the slot that becomes active on the coming wrap edge
  assign index = (index_reg == INDEX_W'(NUM_DIGITS - 1)) ? '0 : index_reg + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg   <= '0;
      index_reg <= '0;
    end else if (wrap) begin
      div_reg   <= '0;
      index_reg <= index;
    end else begin
      div_reg   <= div_reg + 1'b1;
    end
  end
endmodule

// File: rtl/vcr_display_scheduler.sv
// Keypress-to-digit-buffer controller with idle blanking and multiplexed display scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks slots above the entered digit count.
module vcr_display_scheduler
  import vcr_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 25,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  vcr_display_scheduler_if.slave  bus
);
  localparam int COUNT_W = $clog2(NUM_DIGITS + 1);
  localparam int INDEX_W = width_of(NUM_DIGITS);
  localparam int IDLE_W  = width_of(TIMEOUT_TICKS);
  localparam logic [COUNT_W-1:0]    COUNT_FULL = COUNT_W'(NUM_DIGITS);
  localparam logic [IDLE_W-1:0]     IDLE_LAST  = IDLE_W'(TIMEOUT_TICKS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_SLOT0  = ~NUM_DIGITS'(1);

  sched_state_t          state_reg, state_next;
  logic [3:0]            digit_buf_reg  [NUM_DIGITS];
  logic [3:0]            digit_buf_next [NUM_DIGITS];
  logic [3:0]            shift_in       [NUM_DIGITS];
  logic [3:0]            shift_out      [NUM_DIGITS];
  logic [COUNT_W-1:0]    count_reg, count_next, count_inc;
  logic [IDLE_W-1:0]     idle_reg, idle_next;
  logic                  prev_valid_reg;
  logic                  overflow_reg, overflow_next;
  logic                  timeout_reg, timeout_next;
  logic [NUM_DIGITS-1:0] sel_reg, sel_next;
  logic [3:0]            data_reg, data_next;
  logic                  blank_reg, blank_next;
  logic [INDEX_W-1:0]    scan_index;
  logic                  scan_wrap;
  logic                  key_event, is_digit, is_clear, is_bksp, accepted;

  vcr_scan_counter #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS),
    .INDEX_W    (INDEX_W)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .index (scan_index),
    .wrap  (scan_wrap)
  );

  assign key_event = bus.code_valid & ~prev_valid_reg;
  assign is_digit  = (bus.code <= CODE_DIGIT_MAX);
  assign is_clear  = (bus.code == CODE_CLEAR);
  assign is_bksp   = (bus.code == CODE_BKSP);
  assign accepted  = key_event & (is_digit | is_clear | is_bksp);
  assign count_inc = count_reg + 1'b1;

  // Precomputed buffer images for a digit shift-in and a backspace shift-down
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shift
      if (gi == 0) begin : g_lsd
        assign shift_in[gi] = bus.code;
      end else begin : g_in
        assign shift_in[gi] = digit_buf_reg[gi-1];
      end
      if (gi == NUM_DIGITS - 1) begin : g_msd
        assign shift_out[gi] = '0;
      end else begin : g_out
        assign shift_out[gi] = digit_buf_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= BLANK;
      digit_buf_reg  <= '{default: '0};
      count_reg      <= '0;
      idle_reg       <= '0;
      prev_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      timeout_reg    <= 1'b0;
      sel_reg        <= SEL_SLOT0;
      data_reg       <= '0;
      blank_reg      <= 1'b1;
    end else begin
      state_reg      <= state_next;
      digit_buf_reg  <= digit_buf_next;
      count_reg      <= count_next;
      idle_reg       <= idle_next;
      prev_valid_reg <= bus.code_valid;
      overflow_reg   <= overflow_next;
      timeout_reg    <= timeout_next;
      if (scan_wrap) begin
        sel_reg   <= sel_next;
        data_reg  <= data_next;
        blank_reg <= blank_next;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    digit_buf_next = digit_buf_reg;
    count_next     = count_reg;
    idle_next      = idle_reg;
    overflow_next  = 1'b0;
    timeout_next   = 1'b0;
    if (accepted) begin
      // Any accepted key, including a dropped digit, restarts the idle timer
      idle_next = '0;
      unique case (state_reg)
        BLANK: begin
          if (is_digit) begin
            digit_buf_next = shift_in;
            count_next     = COUNT_W'(1);
            state_next     = (NUM_DIGITS == 1) ? FULL : ENTRY;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            digit_buf_next = shift_in;
            count_next     = count_inc;
            if (count_inc == COUNT_FULL) state_next = FULL;
          end else if (is_clear || count_reg == COUNT_W'(1)) begin
            digit_buf_next = '{default: '0};
            count_next     = '0;
            state_next     = BLANK;
          end else begin
            digit_buf_next = shift_out;
            count_next     = count_reg - 1'b1;
          end
        end
        FULL: begin
          if (is_digit) begin
            overflow_next = 1'b1;
          end else if (is_clear) begin
            digit_buf_next = '{default: '0};
            count_next     = '0;
            state_next     = BLANK;
          end else begin
            digit_buf_next = shift_out;
            count_next     = COUNT_FULL - 1'b1;
            state_next     = ENTRY;
          end
        end
        default: ;
      endcase
    end else if (state_reg == BLANK) begin
      idle_next = '0;
    end else if (idle_reg == IDLE_LAST) begin
      idle_next      = '0;
      digit_buf_next = '{default: '0};
      count_next     = '0;
      state_next     = BLANK;
      timeout_next   = 1'b1;
    end else begin
      idle_next = idle_reg + 1'b1;
    end
  end

  always_comb begin
    sel_next             = '1;
    sel_next[scan_index] = 1'b0;
    data_next            = digit_buf_reg[scan_index];
    if (state_reg == BLANK) begin
      blank_next = 1'b1;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      blank_next = (int'(scan_index) >= int'(count_reg));
`else
      blank_next = 1'b0;
`endif
    end
  end

  assign bus.digit_sel   = sel_reg;
  assign bus.digit_data  = data_reg;
  assign bus.blank       = blank_reg;
  assign bus.entry_count = count_reg;
  assign bus.overflow    = overflow_reg;
  assign bus.timeout     = timeout_reg;
endmodule

// File: tb/tb_vcr_display_scheduler.sv
// Randomized bench for vcr_display_scheduler against a queue-based digit-entry model.
module tb_vcr_display_scheduler;
  localparam int ND = 4;
  localparam int SD = 5;
  localparam int TT = 60;
  localparam logic [3:0] K_CLR  = 4'hA;
  localparam logic [3:0] K_BKSP = 4'hB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vcr_display_scheduler_if #(.NUM_DIGITS(ND)) bus ();

  vcr_display_scheduler #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .TIMEOUT_TICKS (TT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: entered digits, most recent first; empty queue means the display is blank
  logic [3:0]    model_q[$];
  int            model_idle;
  int            model_edges;
  bit            model_prev;
  logic [ND-1:0] exp_sel;
  logic [3:0]    exp_data;
  bit            exp_blank, exp_ovf, exp_tmo;

  task automatic check_value(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    model_idle  = 0;
    model_edges = 0;
    model_prev  = 1'b0;
    exp_sel     = '1;
    exp_sel[0]  = 1'b0;
    exp_data    = 4'd0;
    exp_blank   = 1'b1;
    exp_ovf     = 1'b0;
    exp_tmo     = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [3:0] c);
    int idx;
    bit ev;
    model_edges++;
    if (model_edges % SD == 0) begin
      idx        = (model_edges / SD) % ND;
      exp_sel    = '1;
      exp_sel[idx] = 1'b0;
      exp_data   = (idx < model_q.size()) ? model_q[idx] : 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
      exp_blank  = (idx >= model_q.size());
`else
      exp_blank  = (model_q.size() == 0);
`endif
    end
    ev = v && !model_prev;
    model_prev = v;
    exp_ovf = 1'b0;
    exp_tmo = 1'b0;
    if (ev && (c <= 4'd9 || c == K_CLR || c == K_BKSP)) begin
      model_idle = 0;
      if (c <= 4'd9) begin
        if (model_q.size() < ND) model_q.push_front(c);
        else exp_ovf = 1'b1;
      end else if (c == K_CLR) begin
        model_q.delete();
      end else if (model_q.size() > 0) begin
        void'(model_q.pop_front());
      end
    end else if (model_q.size() > 0) begin
      if (model_idle == TT - 1) begin
        model_q.delete();
        model_idle = 0;
        exp_tmo = 1'b1;
      end else begin
        model_idle++;
      end
    end
  endtask

  task automatic check_outputs();
    check_value("entry_count", int'(bus.entry_count), model_q.size());
    check_value("overflow",    int'(bus.overflow),    int'(exp_ovf));
    check_value("timeout",     int'(bus.timeout),     int'(exp_tmo));
    check_value("digit_sel",   int'(bus.digit_sel),   int'(exp_sel));
    check_value("digit_data",  int'(bus.digit_data),  int'(exp_data));
    check_value("blank",       int'(bus.blank),       int'(exp_blank));
  endtask

  task automatic step(input bit v, input logic [3:0] c);
    bus.code_valid = v;
    bus.code       = c;
    @(posedge clk);
    model_edge(v, c);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic press(input logic [3:0] c);
    step(1'b1, c);
    step(1'b0, c);
    $display("[TB] key %h -> count %0d", c, model_q.size());
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b0, 4'd0);
  endtask

  initial begin
    bus.code_valid = 1'b0;
    bus.code       = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // Held code_valid yields a single event
    repeat (10) step(1'b1, 4'd3);
    step(1'b0, 4'd3);
    check_value("held_count", int'(bus.entry_count), 1);
    $display("[TB] held key 3 -> count %0d", model_q.size());

    // Fill, then overflow
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check_value("full_count", int'(bus.entry_count), 4);
    press(4'd5);
    idle_cycles(2 * SD);

    // Backspace down to blank
    press(K_CLR);
    press(4'd7); press(4'd8); press(K_BKSP);
    check_value("bksp_count", int'(bus.entry_count), 1);
    press(K_BKSP);
    idle_cycles(ND * SD);

    // Idle timeout, then an event landing on the timeout cycle
    press(4'd9);
    idle_cycles(TT - 1);
    check_value("timeout_pulse", int'(bus.timeout), 1);
    check_value("timeout_count", int'(bus.entry_count), 0);
    press(4'd9);
    idle_cycles(TT - 2);
    step(1'b1, 4'd5);
    check_value("coinc_count", int'(bus.entry_count), 2);
    check_value("coinc_timeout", int'(bus.timeout), 0);
    step(1'b0, 4'd5);

    // Scan over buffer 0012
    press(K_CLR);
    press(4'd1); press(4'd2);
    idle_cycles(5 * SD);

    // Asynchronous reset mid-entry
    press(K_CLR);
    press(4'd1); press(4'd2); press(4'd3);
    check_value("pre_reset_count", int'(bus.entry_count), 3);
    #2 reset = 1'b1;
    #1;
    check_value("rst_count", int'(bus.entry_count), 0);
    check_value("rst_overflow", int'(bus.overflow), 0);
    check_value("rst_timeout", int'(bus.timeout), 0);
    check_value("rst_sel", int'(bus.digit_sel), 14);
    check_value("rst_data", int'(bus.digit_data), 0);
    check_value("rst_blank", int'(bus.blank), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_outputs();

    // Randomized key traffic
    for (int n = 0; n < 250; n++) begin
      logic [3:0] c;
      int hold;
      int gap;
      c    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 7) == 0) ? $urandom_range(40, 70) : $urandom_range(0, 3);
      repeat (hold) step(1'b1, c);
      repeat (gap) step(1'b0, c);
      $display("[TB] txn %0d code %h hold %0d gap %0d -> count %0d", n, c, hold, gap, model_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
